// File: rtl/dual_fetch_unit.sv
// Fetch-side driver for a dual-issue instruction memory: owns the fetch PC, buffers fetched
// instruction pairs in a small FIFO and presents them to decode with a valid/ready handshake.
module dual_fetch_unit #(
  parameter int          FQ_DEPTH = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [15:0]                redirect_pc,
  input  logic                       halt_req,
  output logic [15:0]                mem_pc,
  output logic                       mem_en,
  input  logic [31:0]                mem_instr1,
  input  logic [31:0]                mem_instr2,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [31:0]                dec_instr1,
  output logic [31:0]                dec_instr2,
  output logic [15:0]                dec_pc,
  output logic [$clog2(FQ_DEPTH):0]  fq_count,
  output logic [1:0]                 fetch_state
);

  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  state_t          r_state;
  logic [15:0]     r_pc;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic [31:0]     r_q_instr1 [FQ_DEPTH];
  logic [31:0]     r_q_instr2 [FQ_DEPTH];
  logic [15:0]     r_q_pc     [FQ_DEPTH];

  logic            w_not_empty;
  logic            w_full;
  logic            w_dec_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_flush;

  assign w_not_empty = (r_count != '0);
  assign w_full      = (r_count == CW'(FQ_DEPTH));
  assign w_dec_valid = w_not_empty & ~redirect_valid;
  assign w_pop       = w_dec_valid & dec_ready;
  // A full queue may still accept a pair when the head leaves in the same cycle.
  assign w_push      = (r_state == ST_FETCH) & ~redirect_valid & (~w_full | w_pop);
  // Redirects have no effect in IDLE; the FSM always leaves IDLE on its own.
  assign w_flush     = redirect_valid & (r_state != ST_IDLE);

  // NOTE: the pair storage has no reset; dec_* are masked to zero while the queue is empty,
  // so the stale contents are never observable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr1[r_tail] <= mem_instr1;
      r_q_instr2[r_tail] <= mem_instr2;
      r_q_pc[r_tail]     <= r_pc;
    end
  end

  // NOTE: every sequential assignment uses <= so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE:  r_state <= ST_FETCH;
        ST_FETCH: if (!redirect_valid && halt_req) r_state <= ST_HALT;
        ST_HALT:  if (redirect_valid) r_state <= ST_FETCH;
        default:  r_state <= ST_IDLE;
      endcase

      if (w_flush) begin
        r_pc    <= redirect_pc;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + AW'(1);
          r_pc   <= r_pc + 16'd2;
        end
        if (w_pop) begin
          r_head <= r_head + AW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  assign mem_pc      = r_pc;
  assign mem_en      = w_push;
  assign dec_valid   = w_dec_valid;
  assign dec_instr1  = w_not_empty ? r_q_instr1[r_head] : 32'h0;
  assign dec_instr2  = w_not_empty ? r_q_instr2[r_head] : 32'h0;
  assign dec_pc      = w_not_empty ? r_q_pc[r_head]     : 16'h0;
  assign fq_count    = r_count;
  assign fetch_state = r_state;

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Directed bench for dual_fetch_unit: expected PCs are queued by the stimulus and a monitor
// compares every decode handshake against them; control outputs are checked inline.
module tb_dual_fetch_unit;

  localparam int FQ_DEPTH = 4;
  localparam int CW       = $clog2(FQ_DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          redirect_valid;
  logic [15:0]   redirect_pc;
  logic          halt_req;
  logic [15:0]   mem_pc;
  logic          mem_en;
  logic [31:0]   mem_instr1;
  logic [31:0]   mem_instr2;
  logic          dec_valid;
  logic          dec_ready;
  logic [31:0]   dec_instr1;
  logic [31:0]   dec_instr2;
  logic [15:0]   dec_pc;
  logic [CW-1:0] fq_count;
  logic [1:0]    fetch_state;
  logic [15:0]   w_pc_plus1;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_pops   = 0;
  logic [15:0]   exp_q[$];

  dual_fetch_unit #(.FQ_DEPTH(FQ_DEPTH), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .mem_pc         (mem_pc),
    .mem_en         (mem_en),
    .mem_instr1     (mem_instr1),
    .mem_instr2     (mem_instr2),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr1     (dec_instr1),
    .dec_instr2     (dec_instr2),
    .dec_pc         (dec_pc),
    .fq_count       (fq_count),
    .fetch_state    (fetch_state)
  );

  // Instruction memory: word i holds 32'h1000_0000 + i, 16-bit word address space.
  assign w_pc_plus1 = mem_pc + 16'd1;
  assign mem_instr1 = 32'h1000_0000 + {16'h0000, mem_pc};
  assign mem_instr2 = 32'h1000_0000 + {16'h0000, w_pc_plus1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load_exp(input logic [15:0] start, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(start + 16'(2 * k));
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Monitor: a handshake visible mid-cycle is consumed at the next rising edge.
  initial begin
    logic [15:0] p;
    logic [15:0] p1;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && dec_valid && dec_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pop: got pc %h expected no pair (t=%0t)", dec_pc, $time);
        end else begin
          p  = exp_q.pop_front();
          p1 = p + 16'd1;
          check("pop_pc", {16'h0, dec_pc}, {16'h0, p});
          check("pop_instr1", dec_instr1, 32'h1000_0000 + {16'h0, p});
          check("pop_instr2", dec_instr2, 32'h1000_0000 + {16'h0, p1});
        end
      end
    end
  end

  initial begin
    // T1: reset with unknown inputs
    rst            = 1'b1;
    redirect_valid = 1'bx;
    redirect_pc    = 'x;
    halt_req       = 1'bx;
    dec_ready      = 1'bx;
    #1;
    check("rst_mem_en", {31'h0, mem_en}, 32'h0);
    check("rst_dec_valid", {31'h0, dec_valid}, 32'h0);
    check("rst_mem_pc", {16'h0, mem_pc}, 32'h0);
    check("rst_state", {30'h0, fetch_state}, 32'h0);
    check("rst_count", {29'h0, fq_count}, 32'h0);
    check("rst_dec_pc", {16'h0, dec_pc}, 32'h0);

    next_cycle();
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    halt_req       = 1'b0;
    dec_ready      = 1'b0;

    next_cycle();
    rst = 1'b0;
    load_exp(16'h0000, 8);
    #1;
    check("idle_state", {30'h0, fetch_state}, 32'h0);
    check("idle_mem_en", {31'h0, mem_en}, 32'h0);

    // T2: streaming, one pair per cycle
    next_cycle();
    dec_ready = 1'b1;
    #1;
    check("first_mem_en", {31'h0, mem_en}, 32'h1);
    check("first_mem_pc", {16'h0, mem_pc}, 32'h0);
    check("first_state", {30'h0, fetch_state}, 32'h1);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      #1;
      check("stream_count", {29'h0, fq_count}, 32'd1);
      check("stream_mem_pc", {16'h0, mem_pc}, 32'(2 * i));
      check("stream_dec_valid", {31'h0, dec_valid}, 32'h1);
    end

    // T3: backpressure from an empty queue at pc 0
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    dec_ready      = 1'b0;
    load_exp(16'h0000, 8);
    #1;
    check("redir_dec_valid", {31'h0, dec_valid}, 32'h0);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("bp_start_count", {29'h0, fq_count}, 32'd0);
    repeat (4) next_cycle();
    #1;
    check("bp_full_count", {29'h0, fq_count}, 32'd4);
    check("bp_full_mem_en", {31'h0, mem_en}, 32'h0);
    check("bp_full_mem_pc", {16'h0, mem_pc}, 32'h8);
    next_cycle();
    #1;
    check("bp_hold_mem_pc", {16'h0, mem_pc}, 32'h8);
    check("bp_hold_dec_pc", {16'h0, dec_pc}, 32'h0);
    next_cycle();
    dec_ready = 1'b1;
    #1;
    check("bp_pop_push_en", {31'h0, mem_en}, 32'h1);
    next_cycle();
    dec_ready = 1'b0;
    #1;
    check("bp_after_count", {29'h0, fq_count}, 32'd4);
    check("bp_after_mem_pc", {16'h0, mem_pc}, 32'hA);
    check("bp_after_mem_en", {31'h0, mem_en}, 32'h0);
    check("bp_after_dec_pc", {16'h0, dec_pc}, 32'h2);

    // T4: redirect with three pairs queued
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0030;
    load_exp(16'h0030, 4);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("r30_mem_pc", {16'h0, mem_pc}, 32'h30);
    repeat (3) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    dec_ready      = 1'b1;
    load_exp(16'h0040, 1);
    #1;
    check("r40_pre_count", {29'h0, fq_count}, 32'd3);
    check("r40_dec_valid", {31'h0, dec_valid}, 32'h0);
    check("r40_mem_en", {31'h0, mem_en}, 32'h0);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("r40_count", {29'h0, fq_count}, 32'd0);
    check("r40_mem_pc", {16'h0, mem_pc}, 32'h40);
    check("r40_empty_valid", {31'h0, dec_valid}, 32'h0);
    next_cycle();
    #1;
    check("r40_first_valid", {31'h0, dec_valid}, 32'h1);
    check("r40_first_pc", {16'h0, dec_pc}, 32'h40);

    // T5: halt at pc 6, drain, resume via redirect
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    load_exp(16'h0000, 4);
    next_cycle();
    redirect_valid = 1'b0;
    repeat (3) next_cycle();
    halt_req = 1'b1;
    #1;
    check("halt_mem_pc", {16'h0, mem_pc}, 32'h6);
    check("halt_last_push", {31'h0, mem_en}, 32'h1);
    next_cycle();
    halt_req = 1'b0;
    #1;
    check("halt_state", {30'h0, fetch_state}, 32'h2);
    check("halt_mem_en", {31'h0, mem_en}, 32'h0);
    check("halt_count", {29'h0, fq_count}, 32'd1);
    next_cycle();
    #1;
    check("halt_drained", {29'h0, fq_count}, 32'd0);
    check("halt_dec_valid", {31'h0, dec_valid}, 32'h0);
    check("halt_still_off", {31'h0, mem_en}, 32'h0);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0010;
    load_exp(16'h0010, 1);
    #1;
    check("resume_redir_en", {31'h0, mem_en}, 32'h0);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("resume_state", {30'h0, fetch_state}, 32'h1);
    check("resume_mem_pc", {16'h0, mem_pc}, 32'h10);
    check("resume_mem_en", {31'h0, mem_en}, 32'h1);
    next_cycle();
    #1;
    check("resume_dec_pc", {16'h0, dec_pc}, 32'h10);

    // T6: PC wrap and asynchronous reset between edges
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    dec_ready      = 1'b0;
    load_exp(16'hFFFE, 2);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("wrap_mem_pc_fffe", {16'h0, mem_pc}, 32'hFFFE);
    next_cycle();
    #1;
    check("wrap_mem_pc_0", {16'h0, mem_pc}, 32'h0);
    check("wrap_mem_en", {31'h0, mem_en}, 32'h1);
    next_cycle();
    #1;
    check("wrap_count", {29'h0, fq_count}, 32'd2);
    check("wrap_dec_pc", {16'h0, dec_pc}, 32'hFFFE);
    check("wrap_dec_instr1", dec_instr1, 32'h1000_FFFE);
    check("wrap_dec_instr2", dec_instr2, 32'h1000_FFFF);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_count", {29'h0, fq_count}, 32'd0);
    check("arst_dec_valid", {31'h0, dec_valid}, 32'h0);
    check("arst_state", {30'h0, fetch_state}, 32'h0);
    check("arst_mem_pc", {16'h0, mem_pc}, 32'h0);
    check("arst_mem_en", {31'h0, mem_en}, 32'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    #1;
    check("post_rst_mem_en", {31'h0, mem_en}, 32'h1);
    check("post_rst_mem_pc", {16'h0, mem_pc}, 32'h0);
    check("total_pops", 32'(n_pops), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
